mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/AluCtrlSig_pkg.sv | 57 +++++
 rtl/mips_alu_dec.sv | 25 ++
 rtl/mips_mc_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/AluCtrlSig_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, R-type functs,
// ALU operation codes and the controller state encoding.
package AluCtrlSig_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 4;

  localparam logic [OP_W-1:0] ADD_op  = 6'h00;
  localparam logic [OP_W-1:0] J_op    = 6'h02;
  localparam logic [OP_W-1:0] BEQ_op  = 6'h04;
  localparam logic [OP_W-1:0] BNE_op  = 6'h05;
  localparam logic [OP_W-1:0] ADDI_op = 6'h08;
  localparam logic [OP_W-1:0] LW_op   = 6'h23;
  localparam logic [OP_W-1:0] SW_op   = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'd12;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'd13;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;
  localparam logic [1:0] SRC_B_IMM2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_OUT  = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP = 2'd2;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    ADDI_EXEC = 4'd8,
    ADDI_WB   = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } state_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: maps funct to the ALU op code and flags unsupported functs.
module mips_alu_dec
  import AluCtrlSig_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       valid
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      FN_XOR:  alu_ctrl = ALU_XOR;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with a bounded memory-wait timeout.
// Outputs are decoded combinationally from the current state and live inputs.
module mips_mc_ctrl
  import AluCtrlSig_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctrl,
  output logic       pcEn,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic [3:0]       dec_alu_ctrl;
  logic             funct_ok;

  mips_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_ctrl (dec_alu_ctrl),
    .valid    (funct_ok)
  );

  assign timeout = (wait_cnt == CNT_W'(MEM_WAIT_MAX));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait counter: restarts on every state change or timeout, counts unanswered requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state_nxt != state) || mem_err) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    alu_ctrl   = ALU_AND;
    pcEn       = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;

    case (state)
      FETCH: begin
        alu_src_b = SRC_B_FOUR;
        alu_ctrl  = ALU_ADD;
        if (timeout) begin
          mem_err = 1'b1;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pcEn      = 1'b1;
            state_nxt = DECODE;
          end
        end
      end

      DECODE: begin
        alu_src_b = SRC_B_IMM2;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          LW_op, SW_op:   state_nxt = MEM_ADDR;
          ADDI_op:        state_nxt = ADDI_EXEC;
          BEQ_op, BNE_op: state_nxt = BRANCH;
          J_op:           state_nxt = JUMP;
          ADD_op: begin
            if (funct_ok) begin
              state_nxt = R_EXEC;
            end else begin
              illegal_op = 1'b1;
              state_nxt  = FETCH;
            end
          end
          default: begin
            illegal_op = 1'b1;
            state_nxt  = FETCH;
          end
        endcase
      end

      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = ALU_ADD;
        state_nxt = (opcode == LW_op) ? MEM_READ : MEM_WRITE;
      end

      MEM_READ: begin
        if (timeout) begin
          mem_err   = 1'b1;
          state_nxt = FETCH;
        end else begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            state_nxt = MEM_WB;
          end
        end
      end

      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end

      MEM_WRITE: begin
        if (timeout) begin
          mem_err   = 1'b1;
          state_nxt = FETCH;
        end else begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_nxt  = FETCH;
          end
        end
      end

      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_REG;
        alu_ctrl  = dec_alu_ctrl;
        state_nxt = R_WB;
      end

      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end

      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = ALU_ADD;
        state_nxt = ADDI_WB;
      end

      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end

      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_REG;
        alu_ctrl   = ALU_SUB;
        pc_src     = PC_SRC_OUT;
        pcEn       = (opcode == BEQ_op) ? zero : ~zero;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end

      JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pcEn       = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end

      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle vector table plus timeout/reset sequences.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_ctrl;
    logic       pc_en;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;
  } out_t;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ready;
    out_t       exp;
    string      name;
  } vec_t;

  localparam out_t O_F0   = '{mem_req: 1'b1, alu_src_b: 2'd1, alu_ctrl: 4'd2, default: '0};
  localparam out_t O_F1   = '{mem_req: 1'b1, ir_write: 1'b1, alu_src_b: 2'd1, alu_ctrl: 4'd2,
                              pc_en: 1'b1, default: '0};
  localparam out_t O_FTO  = '{alu_src_b: 2'd1, alu_ctrl: 4'd2, mem_err: 1'b1, default: '0};
  localparam out_t O_DEC  = '{alu_src_b: 2'd3, alu_ctrl: 4'd2, default: '0};
  localparam out_t O_ILL  = '{alu_src_b: 2'd3, alu_ctrl: 4'd2, illegal_op: 1'b1, default: '0};
  localparam out_t O_ADDR = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_ctrl: 4'd2, default: '0};
  localparam out_t O_RD   = '{mem_req: 1'b1, iord: 1'b1, default: '0};
  localparam out_t O_MWB  = '{reg_write: 1'b1, mem_to_reg: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t O_WR   = '{mem_req: 1'b1, mem_write: 1'b1, iord: 1'b1, default: '0};
  localparam out_t O_WR1  = '{mem_req: 1'b1, mem_write: 1'b1, iord: 1'b1, instr_done: 1'b1,
                              default: '0};
  localparam out_t O_WTO  = '{mem_err: 1'b1, default: '0};
  localparam out_t O_RWB  = '{reg_write: 1'b1, reg_dst: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t O_AWB  = '{reg_write: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t O_J    = '{pc_src: 2'd2, pc_en: 1'b1, instr_done: 1'b1, default: '0};

  function automatic out_t o_rex(input logic [3:0] alu);
    out_t o;
    o = '0;
    o.alu_src_a = 1'b1;
    o.alu_ctrl  = alu;
    return o;
  endfunction

  function automatic out_t o_br(input logic pc_en);
    out_t o;
    o = '0;
    o.alu_src_a  = 1'b1;
    o.alu_ctrl   = 4'd6;
    o.pc_src     = 2'd1;
    o.pc_en      = pc_en;
    o.instr_done = 1'b1;
    return o;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_ctrl;
  logic       pc_en, instr_done, illegal_op, mem_err;
  out_t       act;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_ctrl   (alu_ctrl),
    .pcEn       (pc_en),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_err    (mem_err)
  );

  assign act = {mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, pc_src, alu_ctrl, pc_en, instr_done, illegal_op, mem_err};

  task automatic check(input out_t exp, input string nm);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic r);
    @(negedge clk);
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = r;
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic r,
                     input out_t e, input string nm);
    vec_t v;
    v.opcode = op;
    v.funct  = fn;
    v.zero   = z;
    v.ready  = r;
    v.exp    = e;
    v.name   = nm;
    tbl.push_back(v);
  endtask

  logic [5:0] fn_list [6] = '{6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26};
  logic [3:0] alu_list[6] = '{4'd6, 4'd0, 4'd1, 4'd12, 4'd7, 4'd13};

  initial begin
    // Per-cycle vectors, starting in FETCH just after reset release
    add(6'h00, 6'h20, 1'b0, 1'b0, O_F0, "fetch_hold");
    add(6'h00, 6'h20, 1'b0, 1'b1, O_F1, "add_fetch");
    add(6'h00, 6'h20, 1'b0, 1'b1, O_DEC, "add_decode");
    add(6'h00, 6'h20, 1'b0, 1'b0, o_rex(4'd2), "add_exec");
    add(6'h00, 6'h20, 1'b0, 1'b0, O_RWB, "add_wb");
    for (int i = 0; i < 6; i++) begin
      add(6'h00, fn_list[i], 1'b0, 1'b1, O_F1, "r_fetch");
      add(6'h00, fn_list[i], 1'b0, 1'b0, O_DEC, "r_decode");
      add(6'h00, fn_list[i], 1'b0, 1'b1, o_rex(alu_list[i]), "r_exec_alu");
      add(6'h00, fn_list[i], 1'b0, 1'b0, O_RWB, "r_wb");
    end
    add(6'h08, 6'h00, 1'b0, 1'b1, O_F1, "addi_fetch");
    add(6'h08, 6'h00, 1'b0, 1'b0, O_DEC, "addi_decode");
    add(6'h08, 6'h00, 1'b0, 1'b0, O_ADDR, "addi_exec");
    add(6'h08, 6'h00, 1'b0, 1'b0, O_AWB, "addi_wb");
    add(6'h04, 6'h00, 1'b1, 1'b1, O_F1, "beq1_fetch");
    add(6'h04, 6'h00, 1'b1, 1'b0, O_DEC, "beq1_decode");
    add(6'h04, 6'h00, 1'b1, 1'b0, o_br(1'b1), "beq_taken");
    add(6'h04, 6'h00, 1'b0, 1'b1, O_F1, "beq0_fetch");
    add(6'h04, 6'h00, 1'b0, 1'b0, O_DEC, "beq0_decode");
    add(6'h04, 6'h00, 1'b0, 1'b0, o_br(1'b0), "beq_not_taken");
    add(6'h05, 6'h00, 1'b1, 1'b1, O_F1, "bne1_fetch");
    add(6'h05, 6'h00, 1'b1, 1'b0, O_DEC, "bne1_decode");
    add(6'h05, 6'h00, 1'b1, 1'b0, o_br(1'b0), "bne_not_taken");
    add(6'h05, 6'h00, 1'b0, 1'b1, O_F1, "bne0_fetch");
    add(6'h05, 6'h00, 1'b0, 1'b0, O_DEC, "bne0_decode");
    add(6'h05, 6'h00, 1'b0, 1'b0, o_br(1'b1), "bne_taken");
    add(6'h02, 6'h00, 1'b0, 1'b1, O_F1, "j_fetch");
    add(6'h02, 6'h00, 1'b0, 1'b0, O_DEC, "j_decode");
    add(6'h02, 6'h00, 1'b0, 1'b0, O_J, "j_jump");
    add(6'h23, 6'h00, 1'b0, 1'b1, O_F1, "lw_fetch");
    add(6'h23, 6'h00, 1'b0, 1'b0, O_DEC, "lw_decode");
    add(6'h23, 6'h00, 1'b0, 1'b0, O_ADDR, "lw_addr");
    add(6'h23, 6'h00, 1'b0, 1'b0, O_RD, "lw_wait1");
    add(6'h23, 6'h00, 1'b0, 1'b0, O_RD, "lw_wait2");
    add(6'h23, 6'h00, 1'b0, 1'b0, O_RD, "lw_wait3");
    add(6'h23, 6'h00, 1'b0, 1'b1, O_RD, "lw_ready");
    add(6'h23, 6'h00, 1'b0, 1'b1, O_MWB, "lw_wb");
    add(6'h2B, 6'h00, 1'b0, 1'b1, O_F1, "sw_fetch");
    add(6'h2B, 6'h00, 1'b0, 1'b0, O_DEC, "sw_decode");
    add(6'h2B, 6'h00, 1'b0, 1'b0, O_ADDR, "sw_addr");
    add(6'h2B, 6'h00, 1'b0, 1'b1, O_WR1, "sw_write");
    add(6'h3F, 6'h00, 1'b0, 1'b1, O_F1, "ill_op_fetch");
    add(6'h3F, 6'h00, 1'b0, 1'b0, O_ILL, "ill_op_decode");
    add(6'h3F, 6'h00, 1'b0, 1'b0, O_F0, "ill_op_refetch");
    add(6'h00, 6'h00, 1'b0, 1'b1, O_F1, "ill_fn_fetch");
    add(6'h00, 6'h00, 1'b0, 1'b0, O_ILL, "ill_fn_decode");
    add(6'h00, 6'h00, 1'b0, 1'b0, O_F0, "ill_fn_refetch");

    repeat (2) @(negedge clk);
    #1;
    check(O_F0, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].opcode, tbl[i].funct, tbl[i].zero, tbl[i].ready);
      check(tbl[i].exp, tbl[i].name);
    end

    // SW whose write is never acknowledged
    drive(6'h2B, 6'h00, 1'b0, 1'b1); check(O_F1, "swto_fetch");
    drive(6'h2B, 6'h00, 1'b0, 1'b0); check(O_DEC, "swto_decode");
    drive(6'h2B, 6'h00, 1'b0, 1'b0); check(O_ADDR, "swto_addr");
    for (int k = 0; k < 15; k++) begin
      drive(6'h2B, 6'h00, 1'b0, 1'b0); check(O_WR, "swto_wait");
    end
    drive(6'h2B, 6'h00, 1'b0, 1'b0); check(O_WTO, "swto_mem_err");
    drive(6'h2B, 6'h00, 1'b0, 1'b0); check(O_F0, "swto_refetch");

    // Reset asserted while a load waits on memory
    drive(6'h23, 6'h00, 1'b0, 1'b1); check(O_F1, "rst_lw_fetch");
    drive(6'h23, 6'h00, 1'b0, 1'b0); check(O_DEC, "rst_lw_decode");
    drive(6'h23, 6'h00, 1'b0, 1'b0); check(O_ADDR, "rst_lw_addr");
    for (int k = 0; k < 5; k++) begin
      drive(6'h23, 6'h00, 1'b0, 1'b0); check(O_RD, "rst_lw_wait");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(O_F0, "rst_mid_read");
    repeat (2) @(negedge clk);
    #1;
    check(O_F0, "rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(O_F0, "rst_release");

    // Counter must restart from zero: FETCH times out after exactly 15 wait cycles
    for (int k = 1; k <= 15; k++) begin
      drive(6'h00, 6'h20, 1'b0, 1'b0);
      check((k == 15) ? O_FTO : O_F0, (k == 15) ? "fetch_timeout" : "fetch_wait");
    end
    drive(6'h00, 6'h20, 1'b0, 1'b0); check(O_F0, "fetch_after_timeout");
    drive(6'h00, 6'h20, 1'b0, 1'b1); check(O_F1, "fetch_recover");
    drive(6'h00, 6'h20, 1'b0, 1'b0); check(O_DEC, "decode_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
